// File: rtl/mdu_divider.sv
// Iterative restoring radix-2 divider for DIV/DIVU: quotient to lo, remainder to hi.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration loop.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       alu_control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [5:0] OP_DIV  = 6'b011010;
  localparam logic [5:0] OP_DIVU = 6'b011011;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_a_raw;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_zero;

  logic             w_signed;
  logic             w_accept;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_signed = (alu_control == OP_DIV);
  assign w_accept = (r_state == S_IDLE) && start &&
                    ((alu_control == OP_DIV) || (alu_control == OP_DIVU));
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_b_zero = (b == '0);
  assign w_a_mag  = w_a_neg ? (~a + 1'b1) : a;
  assign w_b_mag  = w_b_neg ? (~b + 1'b1) : b;

  // Shifted partial remainder needs one extra bit since an unsigned divisor may use all WIDTH bits.
  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_div};
  assign w_ge       = (w_shift >= {1'b0, r_div});
  assign w_rem_next = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

  assign w_q_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_r_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
`ifdef DIV_ZERO_FAST_EN
          w_next = w_b_zero ? S_FIX : S_CALC;
`else
          w_next = S_CALC;
`endif
        end
      end
      S_CALC: begin
        busy = 1'b1;
        if (r_cnt == '0) w_next = S_FIX;
      end
      S_FIX: begin
        busy   = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_a_raw     <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_zero      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt       <= CW'(WIDTH - 1);
            r_rem       <= '0;
            r_quo       <= w_a_mag;
            r_div       <= w_b_mag;
            r_a_raw     <= a;
            r_neg_q     <= w_a_neg ^ w_b_neg;
            r_neg_r     <= w_a_neg;
            r_zero      <= w_b_zero;
            div_by_zero <= 1'b0;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        S_FIX: begin
          // A zero divisor has architecturally defined results regardless of the datapath.
          if (r_zero) begin
            lo          <= '1;
            hi          <= r_a_raw;
            div_by_zero <= 1'b1;
          end else begin
            lo <= w_q_fix;
            hi <= w_r_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_divider.sv
// Self-checking bench for mdu_divider: vector table plus hand-written corner sequences.
// Zero-divisor latency expectation follows DIV_ZERO_FAST_EN.
module tb_mdu_divider;

  localparam logic [5:0] OP_DIV  = 6'b011010;
  localparam logic [5:0] OP_DIVU = 6'b011011;
  localparam int TIMEOUT = 100;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [5:0]  alu_control;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expLo;
    logic [31:0] expHi;
    logic        expDbz;
    int          expLat;
  } vec_t;

  vec_t vecs[12];

  mdu_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_control(alu_control),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one request, scrambles operands after acceptance, and waits for done.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] va, input logic [31:0] vb,
                               output int lat, output int busyCnt, output bit timedOut);
    @(negedge clk);
    alu_control = op;
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~va;
    b = vb ^ 32'h5A5A_0001;
    lat = 0;
    busyCnt = 0;
    timedOut = 1'b1;
    for (int k = 0; k < TIMEOUT; k++) begin
      @(negedge clk);
      if (done) begin
        timedOut = 1'b0;
        break;
      end
      if (busy) busyCnt++;
      @(posedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int busyCnt;
    bit timedOut;
    logic [31:0] savedHi;
    logic [31:0] savedLo;
    int cyc;

    vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0, 33};
    vecs[1]  = '{OP_DIV,  32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33};
    vecs[2]  = '{OP_DIV,  32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 33};
    vecs[3]  = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 33};
    vecs[4]  = '{OP_DIVU, 32'h80000000,   32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 33};
    vecs[5]  = '{OP_DIVU, 32'h00001234,   32'd0,        32'hFFFFFFFF, 32'h00001234, 1'b1, ZERO_LAT};
    vecs[6]  = '{OP_DIVU, 32'd9,          32'd3,        32'd3,        32'd0,        1'b0, 33};
    vecs[7]  = '{OP_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, 33};
    vecs[8]  = '{OP_DIVU, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 33};
    vecs[9]  = '{OP_DIV,  32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, ZERO_LAT};
    vecs[10] = '{OP_DIVU, 32'hFFFFFFFF,   32'hFFFFFFFE, 32'd1,        32'd1,        1'b0, 33};
    vecs[11] = '{OP_DIV,  32'd5,          32'd7,        32'd0,        32'd5,        1'b0, 33};

    rst_n = 1'b0;
    start = 1'b0;
    alu_control = 6'd0;
    a = 32'd0;
    b = 32'd0;
    #23;
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, busyCnt, timedOut);
      checkOutput($sformatf("v%0d_timeout", i), {31'd0, timedOut}, 32'd0);
      checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].expLat);
      checkOutput($sformatf("v%0d_busy_cycles", i), busyCnt, vecs[i].expLat);
      checkOutput($sformatf("v%0d_busy_at_done", i), {31'd0, busy}, 32'd0);
      checkOutput($sformatf("v%0d_lo", i), lo, vecs[i].expLo);
      checkOutput($sformatf("v%0d_hi", i), hi, vecs[i].expHi);
      checkOutput($sformatf("v%0d_dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].expDbz});
      @(negedge clk);
      checkOutput($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
      checkOutput($sformatf("v%0d_idle_busy", i), {31'd0, busy}, 32'd0);
    end

    // start held through the whole operation with changing operands must not restart it
    @(negedge clk);
    alu_control = OP_DIVU;
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    @(posedge clk);
    cyc = 0;
    timedOut = 1'b1;
    for (int k = 0; k < TIMEOUT; k++) begin
      #1;
      a = $urandom;
      b = $urandom | 32'd1;
      @(negedge clk);
      if (done) begin
        timedOut = 1'b0;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    start = 1'b0;
    checkOutput("held_timeout", {31'd0, timedOut}, 32'd0);
    checkOutput("held_latency", cyc, 33);
    checkOutput("held_lo", lo, 32'd14);
    checkOutput("held_hi", hi, 32'd2);
    @(negedge clk);

    // non-divide op must be a no-op
    savedHi = hi;
    savedLo = lo;
    @(negedge clk);
    alu_control = 6'b100000;
    a = 32'd50;
    b = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("badop_busy", {31'd0, busy}, 32'd0);
    checkOutput("badop_done", {31'd0, done}, 32'd0);
    checkOutput("badop_hi", hi, savedHi);
    checkOutput("badop_lo", lo, savedLo);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    alu_control = OP_DIVU;
    a = 32'd1000;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    checkOutput("prereset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_done", {31'd0, done}, 32'd0);
    checkOutput("midreset_hi", hi, 32'd0);
    checkOutput("midreset_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(OP_DIVU, 32'd9, 32'd3, lat, busyCnt, timedOut);
    checkOutput("postreset_timeout", {31'd0, timedOut}, 32'd0);
    checkOutput("postreset_latency", lat, 33);
    checkOutput("postreset_lo", lo, 32'd3);
    checkOutput("postreset_hi", hi, 32'd0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
